// File: rtl/lc3_datapath_p.sv
// LC-3-style datapath: register file, PC, IR, EAB, ALU, NZP, MAR/MDR and req/ack memory port.
// Define DP_BUS_CHECK_EN for a priority bus with sticky contention flag; otherwise the bus ORs its sources.
module lc3_datapath_p #(
    parameter int          WIDTH    = 16,
    parameter int          NREG     = 8,
    parameter logic [15:0] RESET_PC = 16'h3000,
    localparam int         RW       = $clog2(NREG)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [3:0]       bus_sel,
    input  logic             sel_marm,
    input  logic [1:0]       sel_pc,
    input  logic             ld_pc,
    input  logic             ld_ir,
    input  logic             flag_we,
    input  logic             reg_we,
    input  logic             ld_mar,
    input  logic             ld_mdr,
    input  logic             mem_we,
    input  logic [RW-1:0]    dr,
    input  logic [RW-1:0]    sr1,
    input  logic [RW-1:0]    sr2,
    input  logic             sel_eab1,
    input  logic [1:0]       sel_eab2,
    input  logic [1:0]       alu_op,
    input  logic             sel_mdr,
    output logic             mem_req,
    output logic             mem_wr,
    output logic [WIDTH-1:0] mem_addr,
    output logic [WIDTH-1:0] mem_wdata,
    input  logic [WIDTH-1:0] mem_rdata,
    input  logic             mem_ack,
    output logic [WIDTH-1:0] ir,
    output logic             n,
    output logic             z,
    output logic             p,
    output logic             busy,
    output logic             bus_err
);

    // state | meaning
    // IDLE  | no transaction, MAR/MDR loadable
    // READ  | mem_req high, MDR <= mem_rdata on ack
    // WRITE | mem_req and mem_wr high until ack
    typedef enum logic [1:0] {IDLE, READ, WRITE} memState_e;

    localparam logic [WIDTH-1:0] PC_INIT = WIDTH'(RESET_PC);

    memState_e        state;
    logic [WIDTH-1:0] regs [NREG];
    logic [WIDTH-1:0] pc, mar, mdr;
    logic [WIDTH-1:0] ra, rb, bOp, aluOut, eabBase, eabOff, eab, marmOut, bus;

    assign ra       = regs[sr1];
    assign rb       = regs[sr2];
    assign bOp      = ir[5] ? {{(WIDTH-5){ir[4]}}, ir[4:0]} : rb;
    assign eabBase  = sel_eab1 ? ra : pc;
    assign eab      = eabBase + eabOff;
    assign marmOut  = sel_marm ? eab : {{(WIDTH-8){1'b0}}, ir[7:0]};
    assign mem_addr  = mar;
    assign mem_wdata = mdr;

    always_comb begin
        aluOut = '0;
        case (alu_op)
            2'd0:    aluOut = ra + bOp;
            2'd1:    aluOut = ra & bOp;
            2'd2:    aluOut = ~ra;
            default: aluOut = ra;
        endcase
    end

    always_comb begin
        eabOff = '0;
        case (sel_eab2)
            2'd0:    eabOff = '0;
            2'd1:    eabOff = {{(WIDTH-6){ir[5]}}, ir[5:0]};
            2'd2:    eabOff = {{(WIDTH-9){ir[8]}}, ir[8:0]};
            default: eabOff = {{(WIDTH-11){ir[10]}}, ir[10:0]};
        endcase
    end

`ifdef DP_BUS_CHECK_EN
    always_comb begin
        bus = '0;
        if (bus_sel[3])      bus = aluOut;
        else if (bus_sel[2]) bus = mdr;
        else if (bus_sel[1]) bus = pc;
        else if (bus_sel[0]) bus = marmOut;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            bus_err <= 1'b0;
        else if ($countones(bus_sel) > 1)
            bus_err <= 1'b1;
    end
`else
    assign bus = ({WIDTH{bus_sel[3]}} & aluOut) | ({WIDTH{bus_sel[2]}} & mdr)
               | ({WIDTH{bus_sel[1]}} & pc)     | ({WIDTH{bus_sel[0]}} & marmOut);
    assign bus_err = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NREG; i++) regs[i] <= '0;
            pc <= PC_INIT;
            ir <= '0;
            n  <= 1'b0;
            z  <= 1'b1;
            p  <= 1'b0;
        end else begin
            if (reg_we) regs[dr] <= bus;
            if (ld_ir)  ir <= bus;
            if (ld_pc) begin
                case (sel_pc)
                    2'd0:    pc <= pc + 1'b1;
                    2'd1:    pc <= bus;
                    2'd2:    pc <= eab;
                    default: pc <= pc;
                endcase
            end
            if (flag_we) begin
                n <= bus[WIDTH-1];
                z <= (bus == '0);
                p <= !bus[WIDTH-1] && (bus != '0);
            end
        end
    end

    // MAR/MDR only change in IDLE so address and write data stay stable for the whole handshake
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            mem_req <= 1'b0;
            mem_wr  <= 1'b0;
            busy    <= 1'b0;
            mar     <= '0;
            mdr     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (ld_mar) mar <= bus;
                    if (ld_mdr && !sel_mdr) mdr <= bus;
                    if (mem_we) begin
                        state   <= WRITE;
                        mem_req <= 1'b1;
                        mem_wr  <= 1'b1;
                        busy    <= 1'b1;
                    end else if (ld_mdr && sel_mdr) begin
                        state   <= READ;
                        mem_req <= 1'b1;
                        mem_wr  <= 1'b0;
                        busy    <= 1'b1;
                    end
                end
                READ, WRITE: begin
                    if (mem_ack) begin
                        if (state == READ) mdr <= mem_rdata;
                        state   <= IDLE;
                        mem_req <= 1'b0;
                        mem_wr  <= 1'b0;
                        busy    <= 1'b0;
                    end
                end
                default: begin
                    state   <= IDLE;
                    mem_req <= 1'b0;
                    mem_wr  <= 1'b0;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule
